// File: rtl/seq_controller_if.sv
// -----------------------------------------------------------------------------
// seq_controller_if
// Bundles everything the sequencing controller exchanges with the fetch,
// execute and data-memory side of the datapath. The clock and reset are not
// part of this bundle.
//
// Memory handshake: the controller holds mem_req high from MEMORY entry
// through the cycle in which mem_ack is seen high, inclusive. mem_err is
// only meaningful in a cycle where mem_ack is high.
//
// Modports:
//   master - the controller: reads fetch/execute/memory results and drives
//            PC, stage strobes, mem_req and status.
//   slave  - the datapath/memory side: the mirror image.
// -----------------------------------------------------------------------------
interface seq_controller_if;
  logic        run;
  logic        step;
  logic [3:0]  icode;
  logic [3:0]  stat;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valM;
  logic [63:0] valP;
  logic        mem_ack;
  logic        mem_err;
  logic [63:0] PC;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        mem_en;
  logic        wb_en;
  logic        mem_req;
  logic        halted;
  logic [3:0]  stat_out;
  logic [31:0] instr_cnt;

  modport master (
    input  run, step, icode, stat, cnd, valC, valM, valP, mem_ack, mem_err,
    output PC, fetch_en, decode_en, execute_en, mem_en, wb_en, mem_req,
           halted, stat_out, instr_cnt
  );

  modport slave (
    output run, step, icode, stat, cnd, valC, valM, valP, mem_ack, mem_err,
    input  PC, fetch_en, decode_en, execute_en, mem_en, wb_en, mem_req,
           halted, stat_out, instr_cnt
  );
endinterface

// File: rtl/seq_controller.sv
// -----------------------------------------------------------------------------
// seq_controller
// Multi-cycle instruction sequencer. Walks each instruction through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one stage strobe per
// cycle, owns the program counter and the retired-instruction counter, and
// stops in a sticky HALT on a fetch fault, a halt instruction, a memory error
// or a memory timeout. Only reset leaves HALT.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - seq_controller_if.master (control inputs, datapath results,
//                  PC, stage strobes, memory request, status, counter)
//   dbg_state_o  - current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_controller_if.master        bus,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_e;

  localparam int         WW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;

  state_e         state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [3:0]     icode_q, icode_d;
  logic [3:0]     stat_q, stat_d;
  logic           cnd_q, cnd_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;

  logic is_mem;
  logic fetch_en, decode_en, execute_en, mem_en, wb_en, mem_req;

  // Instructions that touch data memory and therefore wait for mem_ack.
  always_comb begin
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      icode_q <= 4'h0;
      stat_q  <= STAT_AOK;
      cnd_q   <= 1'b0;
      cnt_q   <= 32'd0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      stat_q  <= stat_d;
      cnd_q   <= cnd_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    icode_d    = icode_q;
    stat_d     = stat_q;
    cnd_d      = cnd_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    mem_req    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // step is only honoured here; elsewhere it is simply not looked at.
        if (bus.run || bus.step) state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch_en = 1'b1;
        icode_d  = bus.icode;
        if (bus.stat != STAT_AOK) begin
          stat_d  = bus.stat;
          state_d = S_HALT;
        end else if (bus.icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        execute_en = 1'b1;
        cnd_d      = bus.cnd;
        state_d    = S_MEMORY;
      end
      S_MEMORY: begin
        mem_en = 1'b1;
        if (is_mem) begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            // An ack in the last allowed cycle still wins over the timeout.
            wait_d = '0;
            if (bus.mem_err) begin
              stat_d  = STAT_ADR;
              state_d = S_HALT;
            end else begin
              state_d = S_WRITEBACK;
            end
          end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
            wait_d  = '0;
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        case (icode_q)
          4'h8:    pc_d = bus.valC;
          4'h7:    pc_d = cnd_q ? bus.valC : bus.valP;
          4'h9:    pc_d = bus.valM;
          default: pc_d = bus.valP;
        endcase
        cnt_d   = cnt_q + 32'd1;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.PC         = pc_q;
  assign bus.fetch_en   = fetch_en;
  assign bus.decode_en  = decode_en;
  assign bus.execute_en = execute_en;
  assign bus.mem_en     = mem_en;
  assign bus.wb_en      = wb_en;
  assign bus.mem_req    = mem_req;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.stat_out   = stat_q;
  assign bus.instr_cnt  = cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// -----------------------------------------------------------------------------
// tb_seq_controller
// Drives seq_controller instruction by instruction. For every instruction the
// driver plans the whole cycle sequence from the architectural rules (stage
// order, memory wait length, next-PC choice, retire count) and queues the
// outputs each cycle must show; a single compare process checks them on the
// falling edge. Directed scenarios add literal expectations, then a random
// phase mixes instruction types, waits, faults, run/step starts and resets.
// -----------------------------------------------------------------------------
module tb_seq_controller;
  localparam logic [63:0] RPC = 64'h0;
  localparam int          TO  = 16;
  localparam int S_NONE = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  seq_controller_if bus();

  seq_controller #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired, dut state %0d", dbg_state);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_total = 0;
  int n_pass  = 0;
  logic [106:0] exp_q[$];

  // architectural model
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_halted;
  logic [3:0]  m_stat;

  // free-running observation counters (differences taken by the driver)
  int req_cycles  = 0;
  int busy_cycles = 0;

  always @(negedge clk) begin
    if (bus.mem_req) req_cycles++;
    if (bus.fetch_en | bus.decode_en | bus.execute_en | bus.mem_en | bus.wb_en)
      busy_cycles++;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
  endtask

  // compare process: one expected output vector per planned cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0)
      check("cycle", {bus.fetch_en, bus.decode_en, bus.execute_en, bus.mem_en, bus.wb_en,
                      bus.mem_req, bus.halted, bus.stat_out, bus.PC, bus.instr_cnt},
            exp_q.pop_front());
  end

  function automatic logic [106:0] pack(input int stg, input bit req);
    logic [4:0] s;
    s = '0;
    if (stg >= S_F && stg <= S_W) s[5-stg] = 1'b1;
    return {s, req, m_halted, m_stat, m_pc, m_cnt};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic m_reset();
    m_pc = RPC; m_cnt = 32'd0; m_halted = 1'b0; m_stat = 4'd1;
  endtask

  // driver tasks: called at posedge+1; queue this cycle's outputs, then advance
  task automatic cyc(input int stg, input bit req);
    exp_q.push_back(pack(stg, req));
    @(posedge clk); #1;
  endtask

  task automatic noise();
    bus.icode = 4'($urandom); bus.stat = 4'($urandom); bus.cnd = 1'($urandom);
    bus.step  = 1'($urandom); bus.run  = 1'($urandom);
    bus.valC = rnd64(); bus.valM = rnd64(); bus.valP = rnd64();
    bus.mem_ack = 1'($urandom); bus.mem_err = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      noise(); bus.run = 1'b0; bus.step = 1'b0;
      cyc(S_NONE, 1'b0);
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      cyc(S_NONE, 1'b0);
    end
  endtask

  task automatic start(input bit use_step);
    noise(); bus.run = !use_step; bus.step = use_step;
    cyc(S_NONE, 1'b0);
    bus.step = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    m_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_strobes"}, {bus.fetch_en, bus.decode_en, bus.execute_en, bus.mem_en, bus.wb_en}, 5'b0);
    check({tag, "_mem_req"}, bus.mem_req, 1'b0);
    check({tag, "_halted"}, bus.halted, 1'b0);
    check({tag, "_stat_out"}, bus.stat_out, 4'd1);
    check({tag, "_pc"}, bus.PC, RPC);
    check({tag, "_instr_cnt"}, bus.instr_cnt, 32'd0);
  endtask

  // One instruction starting in its FETCH cycle. ack_dly = cycles after MEMORY
  // entry at which mem_ack rises (>= TO means never).
  task automatic exec_instr(input logic [3:0] ic, input logic [3:0] st, input bit c,
                            input int ack_dly, input bit err,
                            input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                            input bit run_after);
    logic [63:0] npc;
    bit is_mem;
    bit acked;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    acked  = 1'b0;
    noise(); bus.icode = ic; bus.stat = st;
    cyc(S_F, 1'b0);
    if (st != 4'd1 || ic == 4'h0) begin
      m_halted = 1'b1;
      m_stat   = (st != 4'd1) ? st : 4'd2;
      return;
    end
    noise(); cyc(S_D, 1'b0);
    noise(); bus.cnd = c; cyc(S_E, 1'b0);
    if (is_mem) begin
      for (int k = 0; k < TO; k++) begin
        noise();
        bus.mem_ack = (k == ack_dly);
        bus.mem_err = bus.mem_ack ? err : 1'($urandom);
        cyc(S_M, 1'b1);
        if (k == ack_dly) begin
          acked = 1'b1;
          break;
        end
      end
      if (!acked || err) begin
        m_halted = 1'b1;
        m_stat   = 4'd3;
        return;
      end
    end else begin
      noise(); cyc(S_M, 1'b0);
    end
    noise(); cyc(S_W, 1'b0);
    noise(); bus.valC = vc; bus.valM = vm; bus.valP = vp; bus.run = run_after;
    cyc(S_NONE, 1'b0);
    if (ic == 4'h8)            npc = vc;
    else if (ic == 4'h7 && c)  npc = vc;
    else if (ic == 4'h9)       npc = vm;
    else                       npc = vp;
    m_pc  = npc;
    m_cnt = m_cnt + 32'd1;
    bus.step = 1'b0;
    if (!run_after) bus.run = 1'b0;
  endtask

  // Step a memory instruction up to stage tgt, then pull reset mid-cycle.
  task automatic reset_in(input int tgt);
    start(1'b1);
    noise(); bus.run = 1'b0; bus.icode = 4'h5; bus.stat = 4'd1; bus.mem_ack = 1'b0;
    cyc(S_F, 1'b0);
    for (int s = S_D; s < tgt; s++) begin
      noise(); bus.run = 1'b0; bus.mem_ack = 1'b0;
      cyc(s, 1'b0);
    end
    bus.run = 1'b0; bus.step = 1'b0; bus.mem_ack = 1'b0;
    if (tgt == S_M) check("mem_req_before_reset", bus.mem_req, 1'b1);
    else            check("execute_before_reset", bus.execute_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(tgt == S_M ? "async_rst_mem" : "async_rst_exec");
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r0, b0;
    bus.run = 0; bus.step = 0; bus.icode = 0; bus.stat = 1; bus.cnd = 0;
    bus.valC = 0; bus.valM = 0; bus.valP = 0; bus.mem_ack = 0; bus.mem_err = 0;
    m_reset();
    @(posedge clk); #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    idle_cycles(3);

    // OPq, PC 0 -> 2, no memory request
    r0 = req_cycles;
    start(1'b0);
    exec_instr(4'h6, 4'd1, 1'b0, 0, 1'b0, rnd64(), rnd64(), 64'h2, 1'b0);
    check("opq_pc", bus.PC, 64'h2);
    check("opq_cnt", bus.instr_cnt, 32'd1);
    check("opq_no_req", req_cycles - r0, 0);
    idle_cycles(2);

    // conditional jump taken / not taken
    start(1'b1);
    exec_instr(4'h7, 4'd1, 1'b1, 0, 1'b0, 64'h100, rnd64(), rnd64(), 1'b0);
    check("jxx_taken_pc", bus.PC, 64'h100);
    start(1'b1);
    exec_instr(4'h7, 4'd1, 1'b0, 0, 1'b0, rnd64(), rnd64(), 64'h9, 1'b0);
    check("jxx_not_taken_pc", bus.PC, 64'h9);
    check("jxx_cnt", bus.instr_cnt, 32'd3);

    // ret with mem_ack 3 cycles after MEMORY entry
    r0 = req_cycles; b0 = busy_cycles;
    start(1'b1);
    exec_instr(4'h9, 4'd1, 1'b0, 3, 1'b0, rnd64(), 64'h40, rnd64(), 1'b0);
    check("ret_pc", bus.PC, 64'h40);
    check("ret_req_cycles", req_cycles - r0, 4);
    check("ret_total_cycles", busy_cycles - b0 + 1, 9);

    // call with ack in the last allowed cycle: no timeout
    start(1'b1);
    exec_instr(4'h8, 4'd1, 1'b0, TO - 1, 1'b0, 64'h7770, rnd64(), rnd64(), 1'b0);
    check("late_ack_pc", bus.PC, 64'h7770);
    check("late_ack_halted", bus.halted, 1'b0);

    // memory timeout
    r0 = req_cycles;
    start(1'b1);
    exec_instr(4'h5, 4'd1, 1'b0, 1000, 1'b0, rnd64(), rnd64(), rnd64(), 1'b0);
    check("timeout_halted", bus.halted, 1'b1);
    check("timeout_stat", bus.stat_out, 4'd3);
    check("timeout_mem_req", bus.mem_req, 1'b0);
    check("timeout_req_cycles", req_cycles - r0, TO);
    check("timeout_pc", bus.PC, 64'h7770);
    check("timeout_cnt", bus.instr_cnt, 32'd5);
    halt_cycles(4);
    do_reset();
    idle_cycles(2);

    // halt instruction; run/step afterwards change nothing
    start(1'b0);
    exec_instr(4'h0, 4'd1, 1'b0, 0, 1'b0, rnd64(), rnd64(), rnd64(), 1'b1);
    halt_cycles(6);
    check("hlt_halted", bus.halted, 1'b1);
    check("hlt_stat", bus.stat_out, 4'd2);
    check("hlt_pc", bus.PC, RPC);
    do_reset();
    idle_cycles(2);

    // memory error and fetch fault
    start(1'b1);
    exec_instr(4'h4, 4'd1, 1'b0, 1, 1'b1, rnd64(), rnd64(), rnd64(), 1'b0);
    check("mem_err_stat", bus.stat_out, 4'd3);
    halt_cycles(2);
    do_reset();
    idle_cycles(1);
    start(1'b1);
    exec_instr(4'h6, 4'd4, 1'b0, 0, 1'b0, rnd64(), rnd64(), rnd64(), 1'b0);
    check("ins_fault_stat", bus.stat_out, 4'd4);
    halt_cycles(2);
    do_reset();
    idle_cycles(1);

    // single step retires exactly one, then idles
    start(1'b1);
    exec_instr(4'h2, 4'd1, 1'b0, 0, 1'b0, rnd64(), rnd64(), 64'h10, 1'b0);
    idle_cycles(3);
    check("step_cnt", bus.instr_cnt, 32'd1);
    check("step_pc", bus.PC, 64'h10);

    // asynchronous reset mid-EXECUTE and mid-MEMORY
    reset_in(S_E);
    idle_cycles(2);
    reset_in(S_M);
    idle_cycles(2);

    // randomized phase
    for (int round = 0; round < 6; round++) begin
      bit running;
      running = 1'b0;
      for (int i = 0; i < 30; i++) begin
        int kind, dly;
        logic [3:0] ic, st;
        bit err, ra;
        kind = $urandom_range(0, 99);
        ic   = 4'($urandom_range(1, 15));
        st   = 4'd1;
        dly  = $urandom_range(0, 4);
        err  = 1'b0;
        ra   = 1'($urandom_range(0, 1));
        if (kind < 3)       st  = 4'($urandom_range(2, 4));
        else if (kind < 5)  ic  = 4'h0;
        else if (kind < 7)  dly = TO + 5;
        else if (kind < 9)  err = 1'b1;
        else if (kind < 12) dly = TO - 1;
        if (!running) begin
          idle_cycles($urandom_range(0, 3));
          start(1'($urandom_range(0, 1)));
        end
        exec_instr(ic, st, 1'($urandom), dly, err, rnd64(), rnd64(), rnd64(), ra);
        if (m_halted) begin
          halt_cycles(3);
          do_reset();
          running = 1'b0;
        end else begin
          running = ra;
        end
      end
      if (running) begin
        // let the in-flight free run be reset from a known place
        do_reset();
      end
      idle_cycles(2);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter: RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter: MEM_TIMEOUT, default 16, max cycles waiting for mem_ack before an ADR fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  level; 1 = free-running instruction execution.
REQ-006 step  input  1  pulse; starts exactly one instruction when idle.
REQ-007 icode  input  4  from fetch stage, valid during FETCH.
REQ-008 stat  input  4  from fetch stage: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-009 cnd  input  1  branch condition from execute, valid in EXECUTE.
REQ-010 valC, valM, valP  input  64 each  constant, memory read value, sequential next PC.
REQ-011 mem_ack  input  1  data memory completion.
REQ-012 mem_err  input  1  data memory address error, qualified by mem_ack.
REQ-013 PC  output  64  current program counter, drives fetch.
REQ-014 fetch_en, decode_en, execute_en, mem_en, wb_en  output  1 each  stage strobes.
REQ-015 mem_req  output  1  data memory request.
REQ-016 halted  output  1  sticky stop indicator.
REQ-017 stat_out  output  4  architectural status, same encoding as stat.
REQ-018 instr_cnt  output  32  retired instruction count.

Function
REQ-019 FSM states: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT; encoding is free.
REQ-020 IDLE -> FETCH on the edge where run=1 or step=1; otherwise stay in IDLE.
REQ-021 step during any state other than IDLE is ignored and not queued.
REQ-022 Each stage strobe is high only in its matching state; at most one strobe is high per cycle.
REQ-023 FETCH latches icode and stat; stat!=AOK -> HALT with stat_out=stat; icode=4'h0 -> HALT with stat_out=2; otherwise -> DECODE.
REQ-024 DECODE and EXECUTE last one cycle each; cnd is latched at the end of EXECUTE.
REQ-025 MEMORY, latched icode in {4,5,8,9,A,B}: mem_req=1 from state entry until the cycle mem_ack=1 inclusive.
REQ-026 MEMORY: mem_ack=1 with mem_err=0 -> WRITEBACK; mem_ack=1 with mem_err=1 -> HALT, stat_out=3.
REQ-027 MEMORY: a wait counter counts cycles with mem_ack=0; reaching MEM_TIMEOUT -> HALT, stat_out=3, mem_req drops.
REQ-028 MEMORY, other icodes: one cycle, mem_req stays 0, -> WRITEBACK.
REQ-029 WRITEBACK lasts one cycle -> PCUPD.
REQ-030 PCUPD new PC: icode 8 -> valC; icode 7 with latched cnd=1 -> valC; icode 9 -> valM; else valP.
REQ-031 PCUPD increments instr_cnt modulo 2^32 (wraps FFFFFFFF -> 0).
REQ-032 PCUPD exit: run=1 -> FETCH; run=0 -> IDLE.
REQ-033 Lowering run mid-instruction completes that instruction, then enters IDLE.
REQ-034 Latency: a non-memory instruction takes 6 cycles FETCH..PCUPD; a memory instruction takes 6+N cycles with mem_ack N cycles after MEMORY entry.
REQ-035 HALT: halted=1, all strobes 0, mem_req 0; PC and instr_cnt frozen (faulting instruction not counted); exit only via reset.

Reset
REQ-036 rst_n=0 immediately forces state=IDLE, PC=RESET_PC, all strobes 0, mem_req 0, halted 0, stat_out=1, instr_cnt 0, wait counter 0, independent of clk.
REQ-037 Reset during MEMORY drops mem_req asynchronously; no PC update occurs.
REQ-038 After rst_n rises, the first FETCH happens no earlier than the first edge with run or step sampled high.

Verification
REQ-039 run=1, icode=6 (OPq), stat=AOK, valP=PC+2 -> strobes in order over 6 cycles, PC 0->2, instr_cnt=1, mem_req never high.
REQ-040 icode=7, cnd=1, valC=0x100 -> PC=0x100; repeat with cnd=0, valP=0x9 -> PC=0x9.
REQ-041 icode=9, mem_ack 3 cycles after MEMORY entry, valM=0x40 -> mem_req high 4 cycles, PC=0x40, 9 cycles total.
REQ-042 icode=5, mem_ack held 0 -> after 16 MEMORY cycles halted=1, stat_out=3, mem_req=0; PC unchanged.
REQ-043 icode=0 in FETCH -> halted=1, stat_out=2; later run/step pulses cause no change until rst_n low.
REQ-044 run=0, one step pulse -> exactly one instruction retires, back to IDLE; rst_n low mid-EXECUTE -> outputs at reset values before next clk edge.
